// File: rtl/frame_loader.sv
// frame_loader
// Turns the SPI slave byte stream into pixels and writes them into the back
// buffer of display_memory. When a frame ends, it waits until display_driver
// reports safe_flip and then toggles the buffer-select level once.
//
// State table:
//   state       | meaning
//   S_IDLE      | waiting for valid&sot to start a frame
//   S_LOAD      | assembling bytes into pixels and writing them
//   S_FLIP_WAIT | frame closed, waiting for safe_flip before toggling flip
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   data       byte from the SPI slave
//   valid      data qualifier, one byte per cycle
//   sot        start of transfer, only honoured together with valid
//   eot        end of transfer strobe, independent of valid
//   safe_flip  display driver is between frames, buffer swap allowed
//   wen        memory write strobe, one cycle per pixel
//   wrow/wcol  write address of the pixel on wen
//   wdata      pixel, RGB888 (R in [23:16], G in [15:8], B in [7:0])
//   flip       buffer-select level, toggles once per completed frame
//   busy       high while in S_LOAD or S_FLIP_WAIT
//   overrun    sticky: byte dropped (frame full or waiting to flip)
//
// Build option FRAME_LOADER_RGB565_EN: when defined, pixels arrive as two
// big-endian RGB565 bytes and are widened to 24 bits by replicating MSBs.
// When undefined, pixels arrive as three RGB888 bytes, R first.

module frame_loader #(
  parameter int ROWS    = 8,
  parameter int COLUMNS = 32,
  parameter int WIDTH   = 24
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [7:0]                                    data,
  input  logic                                          valid,
  input  logic                                          sot,
  input  logic                                          eot,
  input  logic                                          safe_flip,
  output logic                                          wen,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]       wrow,
  output logic [((COLUMNS > 1) ? $clog2(COLUMNS) : 1)-1:0] wcol,
  output logic [WIDTH-1:0]                              wdata,
  output logic                                          flip,
  output logic                                          busy,
  output logic                                          overrun
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 1);

`ifdef FRAME_LOADER_RGB565_EN
  localparam logic [1:0] BYTE_LAST = 2'd1;
  localparam int         SHW       = 8;
`else
  localparam logic [1:0] BYTE_LAST = 2'd2;
  localparam int         SHW       = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_FLIP_WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [SHW-1:0]  shreg;      // earlier bytes of the pixel in progress
  logic [SHW-1:0]  shreg_next;
  logic [RW-1:0]   row_ptr;
  logic [CW-1:0]   col_ptr;
  logic            full;       // every location of the frame has been written
  logic [WIDTH-1:0] pix;       // pixel as it would be if data were its last byte

`ifdef FRAME_LOADER_RGB565_EN
  logic [15:0] word;
  always_comb begin
    word       = {shreg, data};
    shreg_next = data;
    pix        = {word[15:11], word[15:13],
                  word[10:5],  word[10:9],
                  word[4:0],   word[4:2]};
  end
`else
  always_comb begin
    shreg_next = {shreg[7:0], data};
    pix        = {shreg, data};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wen      <= 1'b0;
      wrow     <= '0;
      wcol     <= '0;
      wdata    <= '0;
      flip     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      byte_cnt <= 2'd0;
      shreg    <= '0;
      row_ptr  <= '0;
      col_ptr  <= '0;
      full     <= 1'b0;
    end else begin
      wen <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid && sot) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            overrun  <= 1'b0;
            shreg    <= SHW'(data);
            byte_cnt <= 2'd1;
            row_ptr  <= '0;
            col_ptr  <= '0;
            full     <= 1'b0;
          end
        end

        S_LOAD: begin
          if (valid && sot) begin
            // restart takes priority over a simultaneous eot
            overrun  <= 1'b0;
            shreg    <= SHW'(data);
            byte_cnt <= 2'd1;
            row_ptr  <= '0;
            col_ptr  <= '0;
            full     <= 1'b0;
          end else begin
            if (valid) begin
              if (full) begin
                overrun <= 1'b1;
              end else if (byte_cnt == BYTE_LAST) begin
                wen      <= 1'b1;
                wrow     <= row_ptr;
                wcol     <= col_ptr;
                wdata    <= pix;
                byte_cnt <= 2'd0;
                if (col_ptr == COL_LAST) begin
                  col_ptr <= '0;
                  if (row_ptr == ROW_LAST) full <= 1'b1;
                  else                     row_ptr <= row_ptr + 1'b1;
                end else begin
                  col_ptr <= col_ptr + 1'b1;
                end
              end else begin
                shreg    <= shreg_next;
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
            // a byte on the eot cycle was consumed above; any partial pixel
            // left over is simply dropped
            if (eot) begin
              state    <= S_FLIP_WAIT;
              byte_cnt <= 2'd0;
            end
          end
        end

        S_FLIP_WAIT: begin
          if (valid) overrun <= 1'b1;
          if (safe_flip) begin
            flip  <= ~flip;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
Upstream neighbour of display_memory. Consumes the SPI slave byte stream (data/valid/sot/eot) and assembles bytes into 24-bit pixels. Generates write row/column/strobe into the memory back buffer. At end of frame it toggles the buffer-select level once display_driver reports safe_flip.

Parameters:
ROWS, 8, rows per frame; wrow width is clog2(ROWS)
COLUMNS, 32, columns per frame; wcol width is clog2(COLUMNS)
WIDTH, 24, pixel width written to memory; fixed RGB888, R in [23:16], G in [15:8], B in [7:0]

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-low reset
data  in  8  byte from SPI slave
valid  in  1  data qualifier, one byte per cycle high
sot  in  1  start of transfer, qualified by valid (byte on sot beat is byte 0)
eot  in  1  end of transfer strobe, independent of valid
safe_flip  in  1  driver between frames, buffer swap allowed
wen  out  1  memory write strobe, one cycle per pixel
wrow  out  clog2(ROWS)  write row
wcol  out  clog2(COLUMNS)  write column
wdata  out  WIDTH  pixel
flip  out  1  buffer select level, toggles once per completed frame
busy  out  1  high in LOAD or FLIP_WAIT
overrun  out  1  sticky error, cleared on next accepted sot

Behaviour:
- Reset (rst low, async): state IDLE; wen=0, wrow=0, wcol=0, wdata=0, flip=0, busy=0, overrun=0; byte counter, pixel shift register and address counter cleared.
- States: IDLE, LOAD, FLIP_WAIT.
- IDLE: valid&sot -> LOAD; byte latched as byte 0; address 0,0. Bytes without sot ignored. eot ignored.
- LOAD: each valid byte shifts into pixel register, MSB first. On the final byte of a pixel: next cycle wen=1 with wrow/wcol/wdata of that pixel. Latency is one cycle from last byte to wen.
- Address order: column fastest, 0..COLUMNS-1, then row 0..ROWS-1.
- Frame capacity is ROWS*COLUMNS pixels. Valid bytes beyond it are dropped, set overrun, and wen stays 0. No wrap to 0,0.
- eot in LOAD -> FLIP_WAIT. If valid is high the same cycle, that byte is consumed first; a pixel completed by it is still written.
- Partial pixel at eot is discarded with no write. Unwritten locations keep prior back-buffer contents.
- valid&sot in LOAD restarts the frame: counters reset, that byte is byte 0, overrun cleared, no flip.
- FLIP_WAIT: when safe_flip=1, flip toggles on that edge and the state returns to IDLE. Sampling is registered, so the toggle is one cycle after safe_flip is seen.
- In FLIP_WAIT, valid bytes and sot are dropped and set overrun. The pending flip is never lost.
- eot and sot on the same cycle in LOAD: sot wins (restart).
- busy = (state != IDLE), registered with the state.
- wen is never high in FLIP_WAIT or IDLE, except for the single trailing write of a pixel completed on the eot cycle.
- Mid-frame reset: everything returns to reset values; the frame is abandoned; flip level returns to 0.

Optional Feature:
FRAME_LOADER_RGB565_EN
- Defined: 2 bytes per pixel, RGB565 big-endian. Expanded to 24 bits by MSB replication: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}. Capacity check and partial-pixel rules apply at 2 bytes.
- Undefined: 3 bytes per pixel, RGB888, first byte is R.

Test Plan:
- Full frame: sot+768 RGB888 bytes (byte n = n mod 256), then eot, safe_flip=1 -> 256 wen pulses. First write is row0 col0 0x000102; last is row7 col31 0xFDFEFF. flip 0->1; busy low after.
- Short frame with partial pixel: 7 bytes 0x11..0x17, then eot -> 2 writes (0x111213 @0,0 and 0x141516 @0,1), byte 0x17 discarded, flip toggles.
- Overflow: 771 bytes -> 256 writes, overrun=1, no write to 0,0 after the last pixel. Next sot clears overrun.
- Flip hold: eot with safe_flip=0 for 50 cycles -> flip unchanged, busy=1. Bytes sent meanwhile give no wen and set overrun. safe_flip=1 -> flip toggles exactly once.
- Restart and reset: sot, 4 bytes, sot again, 3 bytes 0xAA 0xBB 0xCC -> write 0xAABBCC @0,0 and no flip. Assert rst mid-LOAD -> all outputs 0 asynchronously.
- RGB565 (macro defined): bytes 0xF8 0x1F -> wdata 0xFF00FF; bytes 0x07 0xE0 -> wdata 0x00FF00.
